// File: rtl/wb_stage.sv
// Write-back stage: aligns control with memory-stage data, extends loads and owns the register file (2 bypassed reads).
// One alignment register, write one cycle later; never stalls. Optional RETIRE_CNT_EN builds a 64-bit retire counter.
module wb_stage #(
  parameter int          NREG    = 32,
  parameter logic [31:0] REG_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic        regWEn_i,
  input  logic [1:0]  wbSel_i,
  input  logic [1:0]  dataSec_i,
  input  logic        unsigned_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] memData_i,
  input  logic [31:0] alu_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic [31:0] rs1Data_o,
  output logic [31:0] rs2Data_o,
  output logic        wbEn_o,
  output logic [4:0]  wbRd_o,
  output logic [31:0] wbData_o,
  output logic [63:0] retired_o
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [1:0] SEL_MEM = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;
  localparam logic [1:0] SEL_RSV = 2'b11;
  localparam logic [1:0] SEC_B   = 2'b00;
  localparam logic [1:0] SEC_H   = 2'b01;

  typedef struct packed {
    logic        valid;
    logic        regWEn;
    logic [1:0]  wbSel;
    logic [1:0]  dataSec;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } ctrl_t;

  ctrl_t       ctrl_d, ctrl_q;
  logic [31:0] ext;
  logic [31:0] rf_q [NREG];

  function automatic logic in_range(input logic [4:0] r);
    return {27'd0, r} < 32'(NREG);
  endfunction

  // Flush only kills the instruction being captured; the stage never holds.
  always_comb begin
    ctrl_d.valid   = valid_i & ~flush_i;
    ctrl_d.regWEn  = regWEn_i;
    ctrl_d.wbSel   = wbSel_i;
    ctrl_d.dataSec = dataSec_i;
    ctrl_d.uns     = unsigned_i;
    ctrl_d.rd      = rd_i;
    ctrl_d.pc4     = pc4_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    ext = memData_i;
    case (ctrl_q.dataSec)
      SEC_B:   ext = {{24{~ctrl_q.uns & memData_i[7]}}, memData_i[7:0]};
      SEC_H:   ext = {{16{~ctrl_q.uns & memData_i[15]}}, memData_i[15:0]};
      default: ext = memData_i;
    endcase
  end

  always_comb begin
    wbData_o = 32'h0;
    case (ctrl_q.wbSel)
      SEL_MEM: wbData_o = ext;
      SEL_ALU: wbData_o = alu_i;
      SEL_PC4: wbData_o = ctrl_q.pc4;
      default: wbData_o = 32'h0;
    endcase
  end

  assign wbEn_o = ctrl_q.valid & ctrl_q.regWEn & (ctrl_q.rd != 5'd0) & (ctrl_q.wbSel != SEL_RSV);
  assign wbRd_o = ctrl_q.rd;

  // Entry 0 stays at zero: reset clears it and wbEn_o never targets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= (i == 0) ? 32'h0 : REG_RST;
      end
    end else if (wbEn_o && in_range(ctrl_q.rd)) begin
      rf_q[ctrl_q.rd[AW-1:0]] <= wbData_o;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] rs, input logic [31:0] rf_val);
    if (rs == 5'd0)                  return 32'h0;
    else if (wbEn_o && rs == wbRd_o) return wbData_o;
    else if (in_range(rs))           return rf_val;
    else                             return 32'h0;
  endfunction

  always_comb begin
    rs1Data_o = read_port(rs1_i, rf_q[rs1_i[AW-1:0]]);
    rs2Data_o = read_port(rs2_i, rf_q[rs2_i[AW-1:0]]);
  end

`ifdef RETIRE_CNT_EN
  logic [63:0] retired_d, retired_q;

  always_comb begin
    retired_d = retired_q + (ctrl_q.valid ? 64'd1 : 64'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= 64'h0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_o = retired_q;
`else
  assign retired_o = 64'h0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/load/PC+4 write-back, x0, flush, async reset, back-to-back bypass.
module tb_wb_stage;

  localparam logic [31:0] RST_VAL = 32'h0000_5A5A;
`ifdef RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush_i, regWEn_i, unsigned_i;
  logic [1:0]  wbSel_i, dataSec_i;
  logic [4:0]  rd_i, rs1_i, rs2_i, wbRd_o;
  logic [31:0] pc4_i, memData_i, alu_i, rs1Data_o, rs2Data_o, wbData_o;
  logic        wbEn_o;
  logic [63:0] retired_o;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_ret = 64'd0;
  logic [63:0] exp_cnt;

  wb_stage #(.NREG(32), .REG_RST(RST_VAL)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .regWEn_i(regWEn_i),
    .wbSel_i(wbSel_i), .dataSec_i(dataSec_i), .unsigned_i(unsigned_i), .rd_i(rd_i),
    .pc4_i(pc4_i), .memData_i(memData_i), .alu_i(alu_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1Data_o(rs1Data_o), .rs2Data_o(rs2Data_o), .wbEn_o(wbEn_o), .wbRd_o(wbRd_o),
    .wbData_o(wbData_o), .retired_o(retired_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic f, input logic wen, input logic [1:0] sel,
                         input logic [1:0] sec, input logic u, input logic [4:0] rd,
                         input logic [31:0] pc4);
    valid_i = v; flush_i = f; regWEn_i = wen; wbSel_i = sel;
    dataSec_i = sec; unsigned_i = u; rd_i = rd; pc4_i = pc4;
  endtask

  task automatic idle();
    present(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; rs1_i = 5'd5; rs2_i = 5'd0;
    memData_i = 32'hFFFF_FFFF; alu_i = 32'hFFFF_FFFF;
    present(1'b1, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd5, 32'hFFFF_FFFF);
    repeat (3) tick();
    #3;
    checks++; if (wbEn_o !== 1'b0) begin errors++; $display("FAIL reset_wben got=%b exp=0", wbEn_o); end
    idle();
    tick();
    rst = 1'b0;
    #3;
    checks++; if (wbEn_o !== 1'b0) begin errors++; $display("FAIL release_wben got=%b exp=0", wbEn_o); end
    checks++; if (rs1Data_o !== RST_VAL) begin errors++; $display("FAIL reset_x5 got=%h exp=%h", rs1Data_o, RST_VAL); end
    checks++; if (rs2Data_o !== 32'h0) begin errors++; $display("FAIL reset_x0 got=%h exp=0", rs2Data_o); end
    checks++; if (retired_o !== 64'h0) begin errors++; $display("FAIL reset_retired got=%h exp=0", retired_o); end
  endtask

  task automatic test_alu_write();
    tick();
    present(1'b1, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd5, 32'h8);
    rs1_i = 5'd5;
    tick();
    idle(); alu_i = 32'h1234; memData_i = 32'h0;
    #3;
    checks++; if (wbEn_o !== 1'b1) begin errors++; $display("FAIL alu_wben got=%b exp=1", wbEn_o); end
    checks++; if (wbRd_o !== 5'd5) begin errors++; $display("FAIL alu_wbrd got=%0d exp=5", wbRd_o); end
    checks++; if (wbData_o !== 32'h1234) begin errors++; $display("FAIL alu_wbdata got=%h exp=1234", wbData_o); end
    checks++; if (rs1Data_o !== 32'h1234) begin errors++; $display("FAIL alu_bypass got=%h exp=1234", rs1Data_o); end
    exp_ret++;
    tick();
    alu_i = 32'hFFFF;
    #3;
    checks++; if (wbEn_o !== 1'b0) begin errors++; $display("FAIL alu_after_wben got=%b exp=0", wbEn_o); end
    checks++; if (rs1Data_o !== 32'h1234) begin errors++; $display("FAIL alu_rf got=%h exp=1234", rs1Data_o); end
  endtask

  task automatic test_load_ext();
    logic [1:0]  sec [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] mem [4] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001, 32'hDEAD_BEEF};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'hDEAD_BEEF};
    for (int i = 0; i < 4; i++) begin
      present(1'b1, 1'b0, 1'b1, 2'b00, sec[i], uns[i], 5'd6, 32'h0);
      tick();
      idle(); memData_i = mem[i];
      #3;
      checks++; if (wbData_o !== exp[i] || wbEn_o !== 1'b1) begin errors++;
        $display("FAIL load_ext[%0d] got=%h en=%b exp=%h en=1", i, wbData_o, wbEn_o, exp[i]); end
      exp_ret++;
      tick();
    end
    rs2_i = 5'd6;
    #3;
    checks++; if (rs2Data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rf got=%h exp=deadbeef", rs2Data_o); end
  endtask

  task automatic test_x0();
    present(1'b1, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd0, 32'h0);
    rs1_i = 5'd0;
    tick();
    idle(); alu_i = 32'hDEAD;
    #3;
    checks++; if (wbEn_o !== 1'b0) begin errors++; $display("FAIL x0_wben got=%b exp=0", wbEn_o); end
    checks++; if (rs1Data_o !== 32'h0) begin errors++; $display("FAIL x0_read got=%h exp=0", rs1Data_o); end
    exp_ret++;
    tick();
    exp_cnt = CNT_EN ? exp_ret : 64'd0;
    checks++; if (retired_o !== exp_cnt) begin errors++; $display("FAIL x0_retired got=%0d exp=%0d", retired_o, exp_cnt); end
  endtask

  task automatic test_flush_pc4();
    present(1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 5'd1, 32'h200);
    tick();
    idle();
    #3;
    checks++; if (wbEn_o !== 1'b0) begin errors++; $display("FAIL flush_wben got=%b exp=0", wbEn_o); end
    tick();
    exp_cnt = CNT_EN ? exp_ret : 64'd0;
    checks++; if (retired_o !== exp_cnt) begin errors++; $display("FAIL flush_retired got=%0d exp=%0d", retired_o, exp_cnt); end
    rs1_i = 5'd1;
    #1;
    checks++; if (rs1Data_o !== RST_VAL) begin errors++; $display("FAIL flush_x1 got=%h exp=%h", rs1Data_o, RST_VAL); end
    present(1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 5'd1, 32'h104);
    tick();
    idle();
    #3;
    checks++; if (wbData_o !== 32'h104 || wbEn_o !== 1'b1) begin errors++;
      $display("FAIL pc4_wbdata got=%h en=%b exp=104 en=1", wbData_o, wbEn_o); end
    exp_ret++;
    tick();
    #3;
    checks++; if (rs1Data_o !== 32'h104) begin errors++; $display("FAIL pc4_x1 got=%h exp=104", rs1Data_o); end
    exp_cnt = CNT_EN ? exp_ret : 64'd0;
    checks++; if (retired_o !== exp_cnt) begin errors++; $display("FAIL pc4_retired got=%0d exp=%0d", retired_o, exp_cnt); end
  endtask

  task automatic test_async_reset();
    present(1'b1, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd7, 32'h0);
    tick();
    idle(); alu_i = 32'h5555;
    #2;
    rst = 1'b1;
    memData_i = 32'hFFFF_FFFF; alu_i = 32'hFFFF_FFFF;
    #1;
    checks++; if (wbEn_o !== 1'b0) begin errors++; $display("FAIL arst_wben got=%b exp=0", wbEn_o); end
    tick();
    rst = 1'b0;
    rs1_i = 5'd7; rs2_i = 5'd1;
    #3;
    checks++; if (rs1Data_o !== RST_VAL) begin errors++; $display("FAIL arst_x7 got=%h exp=%h", rs1Data_o, RST_VAL); end
    checks++; if (rs2Data_o !== RST_VAL) begin errors++; $display("FAIL arst_x1 got=%h exp=%h", rs2Data_o, RST_VAL); end
    checks++; if (rs1Data_o !== RST_VAL || rs2Data_o !== RST_VAL || wbEn_o !== 1'b0) begin errors++;
      $display("FAIL arst_release got en=%b exp en=0", wbEn_o); end
    checks++; if (retired_o !== 64'h0) begin errors++; $display("FAIL arst_retired got=%0d exp=0", retired_o); end
    exp_ret = 64'd0;
    alu_i = 32'h0; memData_i = 32'h0;
  endtask

  task automatic test_back_to_back();
    rs2_i = 5'd3;
    tick();
    present(1'b1, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd3, 32'h0);
    tick();
    present(1'b1, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd3, 32'h0);
    alu_i = 32'h1;
    #3;
    checks++; if (rs2Data_o !== 32'h1) begin errors++; $display("FAIL b2b_first got=%h exp=1", rs2Data_o); end
    tick();
    idle(); alu_i = 32'h2;
    #3;
    checks++; if (rs2Data_o !== 32'h2 || wbEn_o !== 1'b1) begin errors++;
      $display("FAIL b2b_second got=%h en=%b exp=2 en=1", rs2Data_o, wbEn_o); end
    exp_ret += 64'd2;
    tick();
    alu_i = 32'h0;
    #3;
    checks++; if (rs2Data_o !== 32'h2) begin errors++; $display("FAIL b2b_rf got=%h exp=2", rs2Data_o); end
    exp_cnt = CNT_EN ? exp_ret : 64'd0;
    checks++; if (retired_o !== exp_cnt) begin errors++; $display("FAIL b2b_retired got=%0d exp=%0d", retired_o, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_ext();
    test_x0();
    test_flush_pc4();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
